// File: rtl/pc_update_unit_pkg.sv
// ============================================================================
// pc_update_unit_pkg : shared state/kind encodings and defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_update_unit_pkg;

    localparam int PC_WIDTH_DEFAULT    = 16;
    localparam int STACK_DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_WAIT_COND = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CF_CALL   = 2'd0,
        CF_RET    = 2'd1,
        CF_BRANCH = 2'd2
    } cf_kind_t;

    // call wins over ret, ret over branch
    function automatic cf_kind_t decode_kind(input logic is_call, input logic is_ret);
        if (is_call)
            return CF_CALL;
        else if (is_ret)
            return CF_RET;
        else
            return CF_BRANCH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_update_unit_ret_addr_stack.sv
// ============================================================================
// ret_addr_stack : LIFO of return addresses; overflowing pushes and
// underflowing pops are dropped. Revision: 1.0
// ============================================================================
`default_nettype none

module ret_addr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit keeps full and empty distinct
    logic [AW:0]      sp;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        full    = (sp == (AW+1)'(DEPTH));
        empty   = (sp == '0);
        top_idx = sp[AW-1:0] - AW'(1);
        rdata   = mem[top_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sp <= '0;
        else if (push && !full)
            sp <= sp + (AW+1)'(1);
        else if (pop && !empty)
            sp <= sp - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[AW-1:0]] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ============================================================================
// pc_update_unit : resolves next PC for call/ret/branch hazards and pulses
// PC_update once per hazard. Revision: 1.0
// ============================================================================
`default_nettype none

module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter int STACK_DEPTH  = STACK_DEPTH_DEFAULT,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PC_hazard,
    input  logic                call,
    input  logic                ret,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                cond_valid,
    input  logic                cond_taken,
    output logic                PC_update,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                busy,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t              state, next_state;
    cf_kind_t            kind;
    logic                trigger;
    logic                stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_WIDTH-1:0] stk_rdata;
    logic [PC_WIDTH-1:0] dest_now, load_value;
    logic [PC_WIDTH-1:0] cap_pc, cap_target, cap_dest;
    logic [CNT_W-1:0]    drain_cnt;

    ret_addr_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (pc_in),
        .rdata (stk_rdata),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        trigger  = (state == ST_IDLE) && PC_hazard && (call || ret || branch);
        kind     = decode_kind(call, ret);
        stk_push = trigger && (kind == CF_CALL);
        stk_pop  = trigger && (kind == CF_RET);
        // An empty stack on ret falls through to the instruction after it
        if (kind == CF_CALL)
            dest_now = target;
        else if (stk_empty)
            dest_now = pc_in;
        else
            dest_now = stk_rdata;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    if (kind == CF_BRANCH)
                        next_state = ST_WAIT_COND;
                    else if (DRAIN_CYCLES > 0)
                        next_state = ST_DRAIN;
                    else
                        next_state = ST_UPDATE;
                end
            end
            ST_DRAIN:     if (drain_cnt == '0) next_state = ST_UPDATE;
            ST_WAIT_COND: if (cond_valid) next_state = ST_UPDATE;
            ST_UPDATE:    next_state = ST_HOLDOFF;
            ST_HOLDOFF:   next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ST_IDLE:      load_value = dest_now;
            ST_WAIT_COND: load_value = cond_taken ? cap_target : cap_pc;
            default:      load_value = cap_dest;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pc          <= '0;
            cap_target      <= '0;
            cap_dest        <= '0;
            drain_cnt       <= '0;
            pc_next         <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (trigger) begin
                cap_pc     <= pc_in;
                cap_target <= target;
                cap_dest   <= dest_now;
                drain_cnt  <= DRAIN_LOAD;
                if (kind == CF_CALL && stk_full)
                    stack_overflow <= 1'b1;
                if (kind == CF_RET && stk_empty)
                    stack_underflow <= 1'b1;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
            if (next_state == ST_UPDATE)
                pc_next <= load_value;
        end
    end

    always_comb begin
        PC_update = (state == ST_UPDATE);
        busy      = (state != ST_IDLE);
    end

endmodule

`default_nettype wire
